adc_serial_rx: RTL and testbench

- Serial front end for the servo loop: drives the ADC chip select and sampling clock, and deserialises the ADC output frame.
- Each frame is 4 leading bits followed by a 12-bit sample, MSB first.
- Sits directly upstream of the I-PD controller in Servo_Top.
- Hands the controller one 12-bit measurement per frame with a single-cycle valid strobe.

---
 rtl/servo_pkg.sv | 27 ++
 rtl/adc_serial_rx_sclk_gen.sv | 54 +++++
 rtl/adc_serial_rx.sv | 142 ++++++++++++++
 tb/tb_adc_serial_rx.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
// Package     : servo_pkg
// Description : Shared types and constants for the servo loop front end.
//               Holds the ADC receiver state encoding, the default ADC frame
//               geometry and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    QUIET = 2'd2
  } state_t;

  localparam int ADC_LEAD_BITS = 4;
  localparam int ADC_DATA_W    = 12;
  localparam int FRAME_BITS    = ADC_LEAD_BITS + ADC_DATA_W;

  // Width of a counter that holds 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_serial_rx_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : sclk_gen
// Description : Free-running divider producing the ADC serial clock
//               (Clock_Muestreo) plus single-cycle enables that coincide
//               with each of its toggles.
// Ports       : Clock_Nexys    - system clock, rising edge
//               Reset          - asynchronous active-low reset
//               Clock_Muestreo - divided serial clock, 0 out of reset
//               rise_tick      - high in the cycle whose edge raises SCLK
//               fall_tick      - high in the cycle whose edge lowers SCLK
// Revision    : 1.0 - initial release
// ============================================================================
module sclk_gen
  import servo_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic Clock_Nexys,
  input  logic Reset,
  output logic Clock_Muestreo,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int              DIV_W    = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             sclk;
  logic             terminal;

  assign terminal = (div_cnt == DIV_LAST);

  always_ff @(posedge Clock_Nexys or negedge Reset) begin
    if (!Reset) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (terminal) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // The enables are decoded from the current SCLK level, so the two can
  // never be high together, even when the divider terminates every cycle.
  assign rise_tick      = terminal & ~sclk;
  assign fall_tick      = terminal &  sclk;
  assign Clock_Muestreo = sclk;

endmodule
`default_nettype wire

// File: rtl/adc_serial_rx.sv
`default_nettype none
// ============================================================================
// Module      : adc_serial_rx
// Description : Serial ADC front end for the servo loop. Drives CS and SCLK,
//               shifts in a frame of LEAD_BITS + DATA_W bits MSB first and
//               presents the measurement with a one-cycle valid strobe.
// Ports       : Clock_Nexys    - system clock, rising edge
//               Reset          - asynchronous active-low reset
//               start          - level, requests continuous conversions
//               data_ADC       - serial data, changes after SCLK falls
//               CS             - ADC chip select, active low
//               Clock_Muestreo - ADC serial clock
//               data_basura    - leading bits of last completed frame
//               sample         - last completed measurement
//               sample_valid   - one-cycle pulse when sample updates
//               busy           - high while CS is low
// Revision    : 1.0 - initial release
// ============================================================================
module adc_serial_rx
  import servo_pkg::*;
#(
  parameter int CLK_DIV   = 25,
  parameter int DATA_W    = ADC_DATA_W,
  parameter int LEAD_BITS = ADC_LEAD_BITS,
  parameter int QUIET_PER = 2
) (
  input  logic                 Clock_Nexys,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 data_ADC,
  output logic                 CS,
  output logic                 Clock_Muestreo,
  output logic [LEAD_BITS-1:0] data_basura,
  output logic [DATA_W-1:0]    sample,
  output logic                 sample_valid,
  output logic                 busy
);

  localparam int               FRAME      = LEAD_BITS + DATA_W;
  localparam int               BIT_W      = $clog2(FRAME + 1);
  localparam int               QW         = cnt_width(QUIET_PER);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME);
  localparam logic [QW-1:0]    QUIET_LAST = QW'(QUIET_PER - 1);

  state_t            state;
  state_t            state_nxt;
  logic              rise_tick;
  logic              fall_tick;
  logic [BIT_W-1:0]  bit_cnt;
  logic [QW-1:0]     quiet_cnt;
  logic [FRAME-1:0]  shift_reg;
  logic              frame_start;
  logic              frame_done;
  logic              cs_reg;

  sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .Clock_Nexys    (Clock_Nexys),
    .Reset          (Reset),
    .Clock_Muestreo (Clock_Muestreo),
    .rise_tick      (rise_tick),
    .fall_tick      (fall_tick)
  );

  always_ff @(posedge Clock_Nexys or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Every transition happens on a fall_tick, so CS moves on the same edge
  // that drives SCLK low and the ADC always sees a full first bit period.
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        if (fall_tick && start) begin
          state_nxt   = CONV;
          frame_start = 1'b1;
        end
      end
      CONV: begin
        if (fall_tick && (bit_cnt == BIT_LAST)) begin
          state_nxt  = QUIET;
          frame_done = 1'b1;
        end
      end
      QUIET: begin
        if (fall_tick && (quiet_cnt == QUIET_LAST)) begin
          if (start) begin
            state_nxt   = CONV;
            frame_start = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock_Nexys or negedge Reset) begin
    if (!Reset) begin
      cs_reg       <= 1'b1;
      bit_cnt      <= '0;
      quiet_cnt    <= '0;
      shift_reg    <= '0;
      sample       <= '0;
      data_basura  <= '0;
      sample_valid <= 1'b0;
    end else begin
      // Registered chip select keeps the ADC pin free of decode glitches.
      cs_reg       <= (state_nxt != CONV);
      sample_valid <= frame_done;

      if (frame_start) begin
        bit_cnt <= '0;
      end else if ((state == CONV) && rise_tick) begin
        shift_reg <= {shift_reg[FRAME-2:0], data_ADC};
        bit_cnt   <= bit_cnt + BIT_W'(1);
      end

      if (frame_done) begin
        sample      <= shift_reg[DATA_W-1:0];
        data_basura <= shift_reg[FRAME-1 -: LEAD_BITS];
        quiet_cnt   <= '0;
      end else if ((state == QUIET) && fall_tick) begin
        quiet_cnt <= quiet_cnt + QW'(1);
      end
    end
  end

  assign CS   = cs_reg;
  assign busy = ~cs_reg;

endmodule
`default_nettype wire

// File: tb/tb_adc_serial_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_serial_rx
// Description : Self-checking bench for adc_serial_rx. Two instances: one at
//               CLK_DIV=25 for the frame scenarios and one at CLK_DIV=1 for
//               the fastest-divider case. A behavioural ADC shifts queued
//               frames out on SCLK falling edges; expected measurements are
//               queued alongside and popped on each sample_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_serial_rx;

  localparam int DIV0 = 25;
  localparam int DIV1 = 1;
  localparam int QP   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        d0 = 1'b0, d1 = 1'b0;
  logic        cs0, cs1, sclk0, sclk1, v0, v1, busy0, busy1;
  logic [3:0]  lb0, lb1;
  logic [11:0] s0, s1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adc_serial_rx #(.CLK_DIV(DIV0), .DATA_W(12), .LEAD_BITS(4), .QUIET_PER(QP)) dut0 (
    .Clock_Nexys(clk), .Reset(rst_n), .start(start0), .data_ADC(d0),
    .CS(cs0), .Clock_Muestreo(sclk0), .data_basura(lb0), .sample(s0),
    .sample_valid(v0), .busy(busy0));

  adc_serial_rx #(.CLK_DIV(DIV1), .DATA_W(12), .LEAD_BITS(4), .QUIET_PER(QP)) dut1 (
    .Clock_Nexys(clk), .Reset(rst_n), .start(start1), .data_ADC(d1),
    .CS(cs1), .Clock_Muestreo(sclk1), .data_basura(lb1), .sample(s1),
    .sample_valid(v1), .busy(busy1));

  // Frames the ADC will send, and expected {lead, sample} results.
  logic [15:0] adc_q0[$], adc_q1[$], exp_q0[$], exp_q1[$];

  // ADC models and monitors, evaluated on the falling system-clock edge.
  logic [15:0] fr0 = '0, fr1 = '0, pss0 = '0, pss1 = '0;
  logic        pcs0 = 1'b1, pcs1 = 1'b1, psclk0 = 1'b0, psclk1 = 1'b0, pv0 = 1'b0, pv1 = 1'b0;
  int idx0 = 0, idx1 = 0;
  int vcnt0 = 0, vcnt1 = 0, multi0 = 0, multi1 = 0, hold0 = 0, hold1 = 0;
  int cs_low0 = 0, last_low0 = 0, cs_high0 = 0, last_high0 = 0;
  int cs_low1 = 0, last_low1 = 0;

  always @(negedge clk) begin
    if (v0) vcnt0++;
    if (v0 && pv0) multi0++;
    if (rst_n && ({lb0, s0} !== pss0) && !v0) hold0++;
    if (!cs0) begin
      if (pcs0) begin
        fr0 = (adc_q0.size() > 0) ? adc_q0.pop_front() : 16'h0000;
        idx0 = 15; d0 = fr0[15];
        cs_low0 = 0; last_high0 = cs_high0;
      end else if (psclk0 && !sclk0 && idx0 > 0) begin
        idx0--; d0 = fr0[idx0];
      end
      cs_low0++;
    end else begin
      if (!pcs0) begin last_low0 = cs_low0; cs_high0 = 0; end
      cs_high0++;
    end
    pcs0 = cs0; psclk0 = sclk0; pv0 = v0; pss0 = {lb0, s0};
  end

  always @(negedge clk) begin
    if (v1) vcnt1++;
    if (v1 && pv1) multi1++;
    if (rst_n && ({lb1, s1} !== pss1) && !v1) hold1++;
    if (!cs1) begin
      if (pcs1) begin
        fr1 = (adc_q1.size() > 0) ? adc_q1.pop_front() : 16'h0000;
        idx1 = 15; d1 = fr1[15];
        cs_low1 = 0;
      end else if (psclk1 && !sclk1 && idx1 > 0) begin
        idx1--; d1 = fr1[idx1];
      end
      cs_low1++;
    end else if (!pcs1) begin
      last_low1 = cs_low1;
    end
    pcs1 = cs1; psclk1 = sclk1; pv1 = v1; pss1 = {lb1, s1};
  end

  // One sampling step: just after the falling edge, once the models settled.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input int which, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (((which == 0) ? v0 : v1) === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_cs(input int which, input logic level, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (((which == 0) ? cs0 : cs1) === level) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rises0(input int n);
    int   c;
    logic p;
    c = 0;
    p = sclk0;
    for (int i = 0; i < n * 2 * DIV0 + 4 && c < n; i++) begin
      step();
      if (sclk0 && !p) c++;
      p = sclk0;
    end
  endtask

  task automatic test_reset();
    int   n;
    logic p;
    bit   alt_ok;
    rst_n = 1'b0;
    repeat (20) step();
    checks++; if (cs0 !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b want 1", cs0); end
    checks++; if (sclk0 !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk0); end
    checks++; if ({lb0, s0} !== 16'h0) begin errors++; $display("FAIL reset_sample: got %h want 0000", {lb0, s0}); end
    checks++; if (v0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL reset_valid_busy: got %b%b want 00", v0, busy0); end
    rst_n = 1'b1;
    // Find a toggle, then count cycles to the next one.
    p = sclk0;
    for (int i = 0; i < 3 * DIV0 && sclk0 === p; i++) step();
    p = sclk0;
    n = 0;
    for (int i = 0; i < 3 * DIV0 && sclk0 === p; i++) begin step(); n++; end
    checks++; if (n !== DIV0) begin errors++; $display("FAIL sclk_half_period: got %0d want %0d", n, DIV0); end
    alt_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      p = sclk1;
      step();
      if (sclk1 === p) alt_ok = 1'b0;
    end
    checks++; if (!alt_ok) begin errors++; $display("FAIL sclk_div1_toggle: got stuck want toggle every cycle"); end
  endtask

  task automatic test_single_frame();
    bit          ok;
    logic [15:0] e;
    int          vb;
    adc_q0.push_back(16'h0A5C); exp_q0.push_back(16'h0A5C);
    vb = vcnt0;
    start0 = 1'b1;
    wait_cs(0, 1'b0, 2 * DIV0 + 4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_cs_fall: got CS high want low"); end
    start0 = 1'b0;
    wait_valid(0, 34 * DIV0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_valid: got timeout want pulse"); end
    else begin
      e = exp_q0.pop_front();
      checks++; if ({lb0, s0} !== e) begin errors++; $display("FAIL single_data: got %h want %h", {lb0, s0}, e); end
      checks++; if (last_low0 !== 32 * DIV0) begin errors++; $display("FAIL single_cs_low: got %0d want %0d", last_low0, 32 * DIV0); end
      step();
      checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL single_valid_width: got %b want 0", v0); end
    end
    repeat (4 * DIV0) step();
    checks++; if (vcnt0 - vb !== 1) begin errors++; $display("FAIL single_valid_count: got %0d want 1", vcnt0 - vb); end
  endtask

  task automatic test_back_to_back();
    bit          ok;
    logic [15:0] e;
    int          vb;
    bit          cs_ok;
    adc_q0.push_back(16'h0FFF); exp_q0.push_back(16'h0FFF);
    adc_q0.push_back(16'h5001); exp_q0.push_back(16'h5001);
    vb = vcnt0;
    start0 = 1'b1;
    for (int f = 0; f < 2; f++) begin
      wait_valid(0, 40 * DIV0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_valid%0d: got timeout want pulse", f); end
      else begin
        e = exp_q0.pop_front();
        checks++; if ({lb0, s0} !== e) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", f, {lb0, s0}, e); end
      end
    end
    start0 = 1'b0;
    checks++; if (last_high0 !== QP * 2 * DIV0) begin errors++; $display("FAIL b2b_quiet: got %0d want %0d", last_high0, QP * 2 * DIV0); end
    cs_ok = 1'b1;
    for (int i = 0; i < 6 * DIV0; i++) begin step(); if (cs0 !== 1'b1) cs_ok = 1'b0; end
    checks++; if (!cs_ok) begin errors++; $display("FAIL b2b_idle: got CS low want high after start dropped"); end
    checks++; if (vcnt0 - vb !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", vcnt0 - vb); end
  endtask

  task automatic test_start_drop();
    bit          ok;
    bit          cs_ok;
    logic [15:0] e;
    int          vb;
    adc_q0.push_back(16'hC123); exp_q0.push_back(16'hC123);
    vb = vcnt0;
    start0 = 1'b1;
    wait_cs(0, 1'b0, 2 * DIV0 + 4, ok);
    wait_rises0(6);
    start0 = 1'b0;
    wait_valid(0, 34 * DIV0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL drop_valid: got timeout want pulse"); end
    else begin
      e = exp_q0.pop_front();
      checks++; if ({lb0, s0} !== e) begin errors++; $display("FAIL drop_data: got %h want %h", {lb0, s0}, e); end
    end
    cs_ok = 1'b1;
    for (int i = 0; i < 8 * DIV0; i++) begin step(); if (cs0 !== 1'b1 || busy0 !== 1'b0) cs_ok = 1'b0; end
    checks++; if (!cs_ok) begin errors++; $display("FAIL drop_idle: got CS low want high"); end
    checks++; if (vcnt0 - vb !== 1) begin errors++; $display("FAIL drop_count: got %0d want 1", vcnt0 - vb); end
  endtask

  task automatic test_short_start();
    logic p;
    bit   cs_ok;
    p = sclk0;
    for (int i = 0; i < 4 * DIV0 && !(p && !sclk0); i++) begin p = sclk0; step(); end
    repeat (5) step();
    start0 = 1'b1;
    repeat (10) step();
    start0 = 1'b0;
    cs_ok = 1'b1;
    for (int i = 0; i < 6 * DIV0; i++) begin step(); if (cs0 !== 1'b1) cs_ok = 1'b0; end
    checks++; if (!cs_ok) begin errors++; $display("FAIL short_start: got frame started want ignored"); end
  endtask

  task automatic test_reset_mid();
    bit          ok;
    logic [15:0] e;
    int          vb;
    adc_q0.push_back(16'hFFFF);
    vb = vcnt0;
    start0 = 1'b1;
    wait_cs(0, 1'b0, 2 * DIV0 + 4, ok);
    wait_rises0(8);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    checks++; if (cs0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL abort_cs: got CS=%b busy=%b want 1 0", cs0, busy0); end
    checks++; if ({lb0, s0} !== 16'h0 || v0 !== 1'b0) begin errors++; $display("FAIL abort_sample: got %h v=%b want 0000 v=0", {lb0, s0}, v0); end
    repeat (5) step();
    rst_n = 1'b1;
    checks++; if (vcnt0 !== vb) begin errors++; $display("FAIL abort_no_valid: got %0d pulses want 0", vcnt0 - vb); end
    adc_q0.push_back(16'h03C3); exp_q0.push_back(16'h03C3);
    wait_cs(0, 1'b0, 2 * DIV0 + 4, ok);
    start0 = 1'b0;
    wait_valid(0, 34 * DIV0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL after_reset_valid: got timeout want pulse"); end
    else begin
      e = exp_q0.pop_front();
      checks++; if ({lb0, s0} !== e) begin errors++; $display("FAIL after_reset_data: got %h want %h", {lb0, s0}, e); end
      checks++; if (last_low0 !== 32 * DIV0) begin errors++; $display("FAIL after_reset_cs_low: got %0d want %0d", last_low0, 32 * DIV0); end
    end
    repeat (4 * DIV0) step();
  endtask

  task automatic test_div1();
    bit          ok;
    logic [15:0] e;
    adc_q1.push_back(16'hA800); exp_q1.push_back(16'hA800);
    start1 = 1'b1;
    wait_cs(1, 1'b0, 8, ok);
    start1 = 1'b0;
    wait_valid(1, 60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL div1_valid: got timeout want pulse"); end
    else begin
      e = exp_q1.pop_front();
      checks++; if ({lb1, s1} !== e) begin errors++; $display("FAIL div1_data: got %h want %h", {lb1, s1}, e); end
      checks++; if (last_low1 !== 32 * DIV1) begin errors++; $display("FAIL div1_cs_low: got %0d want %0d", last_low1, 32 * DIV1); end
    end
    repeat (20) step();
    checks++; if (vcnt1 !== 1) begin errors++; $display("FAIL div1_count: got %0d want 1", vcnt1); end
  endtask

  task automatic test_hold();
    checks++; if (multi0 + multi1 !== 0) begin errors++; $display("FAIL valid_single_cycle: got %0d long pulses want 0", multi0 + multi1); end
    checks++; if (hold0 + hold1 !== 0) begin errors++; $display("FAIL sample_hold: got %0d stray changes want 0", hold0 + hold1); end
    checks++; if (exp_q0.size() + exp_q1.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q0.size() + exp_q1.size()); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_start_drop();
    test_short_start();
    test_reset_mid();
    test_div1();
    test_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
